fixed_point_sqrt: RTL and testbench

FIXED_POINT_SQRT -- requirements
Module: fixed_point_sqrt

---
 rtl/fixed_point_sqrt.sv | 116 +++++++++++
 tb/tb_fixed_point_sqrt.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fixed_point_sqrt.sv
// rtl/fixed_point_sqrt.sv - multi-cycle restoring square root of a signed fixed-point operand
// Two radicand bits per cycle; negative operands short-circuit to DONE with invalid set.
module fixed_point_sqrt #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] radicand,
    output logic [WIDTH-1:0] root,
    output logic             ready,
    output logic             busy,
    output logic             invalid
);

    localparam int E_W   = WIDTH + FBITS;
    localparam int ITER  = E_W / 2;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [E_W-1:0]     e_q, e_d;
    logic [ITER+1:0]    rem_q, rem_d;
    logic [ITER-1:0]    q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   root_q, root_d;
    logic               ready_q, ready_d;
    logic               invalid_q, invalid_d;

    logic               accept;
    logic [ITER+1:0]    trial;
    logic [ITER+1:0]    test_val;
    logic               take;
    logic [ITER-1:0]    q_next;

    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    // The remainder never exceeds ITER significant bits before the shift, so its top bits can drop.
    assign trial    = {rem_q[ITER-1:0], e_q[E_W-1 -: 2]};
    assign test_val = {q_q, 2'b01};
    assign take     = (trial >= test_val);
    assign q_next   = {q_q[ITER-2:0], take};

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        rem_d     = rem_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        root_d    = root_q;
        ready_d   = ready_q;
        invalid_d = invalid_q;

        case (state_q)
            CALC: begin
                e_d   = e_q << 2;
                rem_d = take ? (trial - test_val) : trial;
                q_d   = q_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                    root_d  = WIDTH'(q_next);
                end
            end
            DONE: begin
                ready_d = 1'b1;
            end
            default: begin
            end
        endcase

        if (accept) begin
            e_d       = {radicand, {FBITS{1'b0}}};
            rem_d     = '0;
            q_d       = '0;
            cnt_d     = '0;
            root_d    = '0;
            ready_d   = 1'b0;
            invalid_d = radicand[WIDTH-1];
            state_d   = radicand[WIDTH-1] ? DONE : CALC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            e_q       <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            root_q    <= '0;
            ready_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            root_q    <= root_d;
            ready_q   <= ready_d;
            invalid_q <= invalid_d;
        end
    end

    assign root    = root_q;
    assign ready   = ready_q;
    assign busy    = (state_q == CALC);
    assign invalid = invalid_q;

endmodule

// File: tb/tb_fixed_point_sqrt.sv
// tb/tb_fixed_point_sqrt.sv - directed and random checks of fixed_point_sqrt against an arithmetic model
module tb_fixed_point_sqrt;

    localparam int WIDTH = 32;
    localparam int FBITS = 10;
    localparam int ITER  = (WIDTH + FBITS) / 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] radicand;
    logic [WIDTH-1:0] root;
    logic             ready;
    logic             busy;
    logic             invalid;

    int checks = 0;
    int errors = 0;

    fixed_point_sqrt #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .radicand (radicand),
        .root     (root),
        .ready    (ready),
        .busy     (busy),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << 24;
        while (hi - lo > 1) begin
            longint unsigned mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic logic [WIDTH-1:0] model_root(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) return '0;
        return WIDTH'(isqrt(longint'(v) * (64'd1 << FBITS)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench half a cycle after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] v);
        start    = 1'b1;
        radicand = v;
        @(negedge clk);
        start    = 1'b0;
        chk("ready_drop_on_accept", 32'(ready), 32'd0);
    endtask

    task automatic wait_done(input int inject_at, input logic [WIDTH-1:0] inj_v,
                             output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) nbusy++;
            if (c == inject_at) begin
                start    = 1'b1;
                radicand = inj_v;
            end
            @(negedge clk);
            start    = 1'b0;
            radicand = $urandom;
            if (ready) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] v, input int inject_at,
                          input logic [WIDTH-1:0] inj_v);
        int lat;
        int nbusy;
        logic [WIDTH-1:0] exp_root;
        exp_root = model_root(v);
        launch(v);
        wait_done(inject_at, inj_v, lat, nbusy);
        chk({tag, "_latency"}, 32'(lat), v[WIDTH-1] ? 32'd1 : 32'(ITER + 1));
        chk({tag, "_busy_cycles"}, 32'(nbusy), v[WIDTH-1] ? 32'd0 : 32'(ITER));
        chk({tag, "_root"}, root, exp_root);
        chk({tag, "_invalid"}, 32'(invalid), 32'(v[WIDTH-1]));
    endtask

    initial begin
        int lat;
        int nbusy;
        logic [WIDTH-1:0] v;

        reset    = 1'b1;
        start    = 1'b0;
        radicand = '0;
        repeat (2) @(negedge clk);
        chk("reset_root", root, 32'd0);
        chk("reset_flags", {29'd0, ready, busy, invalid}, 32'd0);
        reset = 1'b0;

        run_op("four", 32'h0000_1000, 0, '0);
        chk("four_const", root, 32'h0000_0800);
        repeat (3) @(negedge clk);
        chk("four_hold_root", root, 32'h0000_0800);
        chk("four_hold_ready", {30'd0, ready, busy}, 32'd2);

        run_op("two", 32'h0000_0800, 0, '0);
        chk("two_const", root, 32'h0000_05A8);
        run_op("max", 32'h7FFF_FFFF, 0, '0);
        chk("max_const", root, 32'h0016_A09E);
        run_op("zero", 32'h0000_0000, 0, '0);
        chk("zero_const", root, 32'h0000_0000);
        run_op("neg4", 32'hFFFF_F000, 0, '0);
        chk("neg4_const", {root[30:0], invalid}, 32'h0000_0001);

        run_op("ign_start", 32'h0000_1000, 5, 32'h0000_2400);
        chk("ign_start_const", root, 32'h0000_0800);
        run_op("b2b", 32'h0000_2400, 0, '0);
        chk("b2b_const", root, 32'h0000_0C00);

        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            if (i % 3 == 0) v[WIDTH-1] = 1'b0;
            run_op("rand", v, 0, '0);
        end

        launch(32'h0000_1000);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_root", root, 32'd0);
        chk("abort_flags", {29'd0, ready, busy, invalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done(0, '0, lat, nbusy);
        chk("abort_no_ready", 32'(lat), 32'd0);
        chk("abort_no_busy", 32'(nbusy), 32'd0);

        run_op("nine", 32'h0000_2400, 0, '0);
        chk("nine_const", root, 32'h0000_0C00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
